// File: rtl/vedic_mul_pipe.sv
// Pipelined Urdhva-Tiryagbhyam multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Ports: clk, rst_n, in_valid/in_ready/in_signed/a/b, out_valid/out_ready/p/out_signed.

module vedic_mul_core #(
  parameter int W = 4
) (
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic [2*W-1:0] z
);
  if (W == 2) begin : g_leaf
    logic p10, p01, p11, c1;
    assign p10  = x[1] & y[0];
    assign p01  = x[0] & y[1];
    assign p11  = x[1] & y[1];
    assign c1   = p10 & p01;
    assign z[0] = x[0] & y[0];
    assign z[1] = p10 ^ p01;
    assign z[2] = p11 ^ c1;
    assign z[3] = p11 & c1;
  end else begin : g_split
    localparam int H = W / 2;
    logic [W-1:0] ll, hl, lh, hh;
    logic [W:0]   mid;
    vedic_mul_core #(.W(H)) u_ll (.x(x[H-1:0]), .y(y[H-1:0]), .z(ll));
    vedic_mul_core #(.W(H)) u_hl (.x(x[W-1:H]), .y(y[H-1:0]), .z(hl));
    vedic_mul_core #(.W(H)) u_lh (.x(x[H-1:0]), .y(y[W-1:H]), .z(lh));
    vedic_mul_core #(.W(H)) u_hh (.x(x[W-1:H]), .y(y[W-1:H]), .z(hh));
    assign mid = {1'b0, hl} + {1'b0, lh};
    assign z = {{W{1'b0}}, ll}
             + ({{(W-1){1'b0}}, mid} << H)
             + {hh, {W{1'b0}}};
  end
endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_signed
);
  localparam int H = WIDTH / 2;

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("vedic_mul_pipe: WIDTH must be a power of two >= 4");
  end

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x,
    input logic             s
  );
    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the right magnitude
    return (s & x[WIDTH-1]) ? -x : x;
  endfunction

  logic stall, adv;
  logic v1, v2, v3;
  logic neg1, sg1, neg2, sg2;
  logic [WIDTH-1:0] a1, b1;
  logic [WIDTH-1:0] ll_c, hl_c, lh_c, hh_c;
  logic [WIDTH-1:0] ll2, hl2, lh2, hh2;
  logic [WIDTH:0]   mid;
  logic [2*WIDTH-1:0] prod, res;

  assign stall     = v3 & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      neg1 <= 1'b0;
      sg1  <= 1'b0;
    end else if (adv) begin
      v1   <= in_valid;
      a1   <= mag(a, in_signed);
      b1   <= mag(b, in_signed);
      neg1 <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      sg1  <= in_signed;
    end
  end

  vedic_mul_core #(.W(H)) u_ll (.x(a1[H-1:0]),     .y(b1[H-1:0]),     .z(ll_c));
  vedic_mul_core #(.W(H)) u_hl (.x(a1[WIDTH-1:H]), .y(b1[H-1:0]),     .z(hl_c));
  vedic_mul_core #(.W(H)) u_lh (.x(a1[H-1:0]),     .y(b1[WIDTH-1:H]), .z(lh_c));
  vedic_mul_core #(.W(H)) u_hh (.x(a1[WIDTH-1:H]), .y(b1[WIDTH-1:H]), .z(hh_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      ll2  <= '0;
      hl2  <= '0;
      lh2  <= '0;
      hh2  <= '0;
      neg2 <= 1'b0;
      sg2  <= 1'b0;
    end else if (adv) begin
      v2   <= v1;
      ll2  <= ll_c;
      hl2  <= hl_c;
      lh2  <= lh_c;
      hh2  <= hh_c;
      neg2 <= neg1;
      sg2  <= sg1;
    end
  end

  // middle cross terms keep their carry before the shift
  assign mid  = {1'b0, hl2} + {1'b0, lh2};
  assign prod = {{WIDTH{1'b0}}, ll2}
              + ({{(WIDTH-1){1'b0}}, mid} << H)
              + {hh2, {WIDTH{1'b0}}};
  assign res  = neg2 ? -prod : prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3         <= 1'b0;
      p          <= '0;
      out_signed <= 1'b0;
    end else if (adv) begin
      v3         <= v2;
      p          <= res;
      out_signed <= sg2;
    end
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe: directed table, random stream, stall, reset,
// plus WIDTH=4 exhaustive and WIDTH=16 random instances.

module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv8 = 0, ir8, is8 = 0, ov8, or8 = 1, os8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic iv4 = 0, ir4, is4 = 0, ov4, or4 = 1, os4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;
  logic iv16 = 0, ir16, is16 = 0, ov16, or16 = 1, os16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  vedic_mul_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .in_signed(is8), .a(a8), .b(b8), .out_valid(ov8),
    .out_ready(or8), .p(p8), .out_signed(os8));
  vedic_mul_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .in_signed(is4), .a(a4), .b(b4), .out_valid(ov4),
    .out_ready(or4), .p(p4), .out_signed(os4));
  vedic_mul_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .in_signed(is16), .a(a16), .b(b16), .out_valid(ov16),
    .out_ready(or16), .p(p16), .out_signed(os16));

  typedef struct {
    longint p;
    bit     s;
    int     acc;
    bit     lat;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          s;
    logic [15:0] p;
  } vec_t;

  exp_t q8[$], q4[$], q16[$];
  int checks = 0, errors = 0, cyc = 0, n8 = 0;
  bit lat_mode = 0;

  // reference: interpret operands, multiply, wrap to 2w bits
  function automatic longint mref(int w, longint x, longint y, bit s);
    longint xv = x, yv = y;
    if (s && x[w-1]) xv = x - (64'sd1 <<< w);
    if (s && y[w-1]) yv = y - (64'sd1 <<< w);
    return (xv * yv) & ((64'sd1 <<< (2 * w)) - 1);
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic pop8();
    exp_t e;
    if (q8.size() == 0) begin
      chk("spurious_out8", 1, 0);
    end else begin
      e = q8.pop_front();
      chk("p8", longint'(p8), e.p);
      chk("out_signed8", longint'(os8), longint'(e.s));
      if (e.lat) chk("latency8", cyc - e.acc, 3);
      n8++;
    end
  endtask

  task automatic step8(bit v, logic [7:0] x, logic [7:0] y, bit s,
                       bit ordy, longint ep);
    @(negedge clk);
    cyc++;
    iv8 = v; a8 = x; b8 = y; is8 = s; or8 = ordy;
    #1;
    if (ov8 && or8) pop8();
    if (iv8 && ir8) q8.push_back('{ep, s, cyc, lat_mode});
  endtask

  task automatic rnd8(bit ordy);
    logic [7:0] x, y;
    bit s;
    x = 8'($urandom);
    y = 8'($urandom);
    s = bit'($urandom_range(0, 1));
    step8(1, x, y, s, ordy, mref(8, longint'(x), longint'(y), s));
  endtask

  task automatic stepw(bit v4, logic [3:0] x4, logic [3:0] y4, bit s4,
                       bit v16, logic [15:0] x16, logic [15:0] y16, bit s16);
    exp_t e;
    @(negedge clk);
    cyc++;
    iv4 = v4; a4 = x4; b4 = y4; is4 = s4;
    iv16 = v16; a16 = x16; b16 = y16; is16 = s16;
    #1;
    if (ov4) begin
      if (q4.size() == 0) chk("spurious_out4", 1, 0);
      else begin
        e = q4.pop_front();
        chk("p4", longint'(p4), e.p);
        chk("out_signed4", longint'(os4), longint'(e.s));
      end
    end
    if (ov16) begin
      if (q16.size() == 0) chk("spurious_out16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("p16", longint'(p16), e.p);
        chk("out_signed16", longint'(os16), longint'(e.s));
      end
    end
    if (iv4 && ir4)
      q4.push_back('{mref(4, longint'(x4), longint'(y4), s4), s4, cyc, 0});
    if (iv16 && ir16)
      q16.push_back('{mref(16, longint'(x16), longint'(y16), s16), s16, cyc, 0});
  endtask

  initial begin
    vec_t tbl[6];
    logic [15:0] hp;
    int n0;
    logic [7:0] sx, sy;
    bit ss;

    tbl[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[1] = '{8'h00, 8'hAB, 1'b0, 16'h0000};
    tbl[2] = '{8'h01, 8'h80, 1'b0, 16'h0080};
    tbl[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[4] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[5] = '{8'h7F, 8'h80, 1'b1, 16'hC080};

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", longint'(ov8), 0);
    chk("rst_p", longint'(p8), 0);
    chk("rst_out_signed", longint'(os8), 0);
    chk("rst_in_ready", longint'(ir8), 1);
    chk("rst_out_valid4", longint'(ov4), 0);
    chk("rst_out_valid16", longint'(ov16), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed vectors, one at a time, latency checked
    lat_mode = 1;
    for (int i = 0; i < 6; i++) begin
      step8(1, tbl[i].a, tbl[i].b, tbl[i].s, 1, longint'(tbl[i].p));
      repeat (3) step8(0, 8'h00, 8'h00, 0, 1, 0);
      chk("dir_drained", q8.size(), 0);
    end

    // back-to-back random stream
    n0 = n8;
    for (int i = 0; i < 100; i++) rnd8(1);
    repeat (4) step8(0, 8'h00, 8'h00, 0, 1, 0);
    chk("stream_count", n8 - n0, 100);
    chk("stream_drained", q8.size(), 0);

    // stall with a full pipe
    lat_mode = 0;
    n0 = n8;
    repeat (3) rnd8(1);
    sx = 8'($urandom); sy = 8'($urandom); ss = 1'b1;
    step8(1, sx, sy, ss, 0, mref(8, longint'(sx), longint'(sy), ss));
    chk("stall_full", longint'(ov8), 1);
    hp = p8;
    for (int i = 0; i < 5; i++) begin
      if (i > 0)
        step8(1, sx, sy, ss, 0, mref(8, longint'(sx), longint'(sy), ss));
      chk("stall_in_ready", longint'(ir8), 0);
      chk("stall_out_valid", longint'(ov8), 1);
      chk("stall_p_hold", longint'(p8), longint'(hp));
    end
    step8(1, sx, sy, ss, 1, mref(8, longint'(sx), longint'(sy), ss));
    repeat (6) step8(0, 8'h00, 8'h00, 0, 1, 0);
    chk("stall_count", n8 - n0, 4);
    chk("stall_drained", q8.size(), 0);

    // reset with beats in flight
    repeat (2) rnd8(1);
    repeat (2) step8(0, 8'h00, 8'h00, 0, 0, 0);
    chk("pre_rst_valid", longint'(ov8), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(ov8), 0);
    chk("midrst_p", longint'(p8), 0);
    chk("midrst_in_ready", longint'(ir8), 1);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    lat_mode = 1;
    step8(1, 8'd12, 8'd13, 0, 1, 64'h009C);
    repeat (3) step8(0, 8'h00, 8'h00, 0, 1, 0);
    chk("post_rst_drained", q8.size(), 0);

    // WIDTH=4 exhaustive (both modes) and WIDTH=16 random
    for (int i = 0; i < 10000; i++) begin
      logic [8:0] idx;
      logic [15:0] x16, y16;
      idx = 9'(i % 512);
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      if (i % 97 == 0) x16 = 16'h8000;
      if (i % 89 == 0) y16 = 16'hFFFF;
      stepw(i < 512, idx[3:0], idx[7:4], idx[8],
            1, x16, y16, bit'($urandom_range(0, 1)));
    end
    repeat (4) stepw(0, 4'h0, 4'h0, 0, 0, 16'h0, 16'h0, 0);
    chk("w4_drained", q4.size(), 0);
    chk("w16_drained", q16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
